pred_issue_ctrl: RTL

Issue controller in front of the decode-stage predicate step. Holds one fetched instruction in a pipeline register and stalls it while its predicate register (bits 31:28) still has outstanding writes. A per-register scoreboard tracks those writes: destinations are recorded at issue and retired at writeback. The instruction is released to the predicate step only when the predicate register value it reads is final.

---
 rtl/pred_issue_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pred_issue_ctrl.sv
// Purpose: one-entry issue register that releases an instruction only once its predicate register (instr[31:28]) has no outstanding writes.
// Latency: 1 cycle from accept to out_valid with no hazard; 1 instruction/cycle sustained.
// Backpressure: in_ready drops while the held instruction is stalled or out_ready is low; out_instr holds steady until accepted.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready/in_instr     fetch side handshake
//   out_valid/out_ready/out_instr  predicate-step side handshake
//   iss_dst_en, iss_dst   destination of the instruction currently offered on out_instr
//   wb_en, wb_addr        register writeback retiring one outstanding write
//   flush                 drop the held instruction (scoreboard keeps counting)
//   hazard_stall          held instruction blocked by the scoreboard
//   stall_cnt             saturating count of hazard_stall cycles
//   sb_err                sticky: writeback to a register with no outstanding write
//
// Build option: define PRED_BYPASS_EN to release the instruction in the same
// cycle as the final writeback to its predicate register (needs a write-first
// register file read port).

module pred_issue_ctrl #(
   parameter int CNT_W = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] in_instr,
   output logic        in_ready,
   output logic        out_valid,
   output logic [31:0] out_instr,
   input  logic        out_ready,
   input  logic        iss_dst_en,
   input  logic [3:0]  iss_dst,
   input  logic        wb_en,
   input  logic [3:0]  wb_addr,
   input  logic        flush,
   output logic        hazard_stall,
   output logic [15:0] stall_cnt,
   output logic        sb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             hold_valid;
   logic [31:0]      hold_instr;
   // Entry 0 is only ever reset, so it reads as a constant zero and register 0
   // can never look pending.
   logic [CNT_W-1:0] cnt [16];

   logic [3:0]       pred_addr;
   logic             pred_pend;
   logic             raw_haz;
   logic             full_haz;
   logic             hazard;
   logic             issue;
   logic             accept;
   logic             wb_bad;
   logic [15:0]      inc_vec;
   logic [15:0]      dec_vec;

   assign pred_addr = hold_instr[31:28];
   assign pred_pend = (pred_addr != 4'd0) && (cnt[pred_addr] != '0);

`ifdef PRED_BYPASS_EN
   // The last outstanding write lands this cycle; a write-first read port
   // already returns the final value, so the hazard is lifted early.
   assign raw_haz = pred_pend &&
                    !((cnt[pred_addr] == CNT_ONE) && wb_en && (wb_addr == pred_addr));
`else
   assign raw_haz = pred_pend;
`endif

   // Structural stall: one more issue to a saturated counter would wrap it.
   assign full_haz = iss_dst_en && (iss_dst != 4'd0) && (cnt[iss_dst] == CNT_MAX);

   assign hazard       = hold_valid && (raw_haz || full_haz);
   assign out_valid    = hold_valid && !hazard && !flush;
   assign hazard_stall = hazard && !flush;
   assign issue        = out_valid && out_ready;
   assign in_ready     = !flush && (!hold_valid || issue);
   assign accept       = in_valid && in_ready;
   assign out_instr    = hold_instr;

   assign wb_bad = wb_en && (wb_addr != 4'd0) && (cnt[wb_addr] == '0);

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int r = 1; r < 16; r++) begin
         inc_vec[r] = issue && iss_dst_en && (iss_dst == 4'(r));
         dec_vec[r] = wb_en && (wb_addr == 4'(r)) && (cnt[r] != '0);
      end
   end

   // Holding register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_instr <= 32'h0000_0000;
      end else if (flush) begin
         hold_valid <= 1'b0;
      end else if (accept) begin
         hold_valid <= 1'b1;
         hold_instr <= in_instr;
      end else if (issue) begin
         hold_valid <= 1'b0;
      end
   end

   // Scoreboard: an issue and a writeback to the same register cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 16; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         for (int r = 1; r < 16; r++) begin
            if (inc_vec[r] && !dec_vec[r]) begin
               cnt[r] <= cnt[r] + CNT_ONE;
            end else if (dec_vec[r] && !inc_vec[r]) begin
               cnt[r] <= cnt[r] - CNT_ONE;
            end
         end
      end
   end

   // Status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 16'h0000;
         sb_err    <= 1'b0;
      end else begin
         if (hazard_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
         end
         if (wb_bad) begin
            sb_err <= 1'b1;
         end
      end
   end

endmodule
